// File: rtl/spi_mem_ctrl.sv
// SPI mode-0 memory controller: turns single-word core requests into
// READ (0x03) / WRITE (0x02) transactions with a 24-bit address.
module spi_mem_ctrl #(
    parameter int unsigned HALF_PERIOD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} state_t;

    localparam logic [7:0] HP_LAST = 8'(HALF_PERIOD - 1);

    state_t      state, state_d;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [63:0] tx;
    logic [31:0] rx;
    logic        write_q;
    logic [1:0]  size_q;

    logic        accept, active, tick, sclk_rise, sclk_fall, phase_end;
    logic [7:0]  cmd;
    logic [4:0]  data_last;
    logic [31:0] wdata_stream;
    logic [31:0] rdata_asm;

    always_comb begin
        accept       = req_valid && req_ready;
        active       = (state == CMD) || (state == ADDR) || (state == DATA);
        tick         = active && (div_cnt == HP_LAST);
        sclk_rise    = tick && !spi_sclk;
        sclk_fall    = tick && spi_sclk;
        phase_end    = sclk_fall && (bit_cnt == '0);
        cmd          = req_write ? 8'h02 : 8'h03;
        data_last    = (size_q == 2'd0) ? 5'd7 : (size_q == 2'd1) ? 5'd15 : 5'd31;
        // little-endian bytes, each sent MSB first from the top of the shifter
        wdata_stream = {req_wdata[7:0], req_wdata[15:8], req_wdata[23:16], req_wdata[31:24]};
        case (size_q)
            2'd0:    rdata_asm = {24'h0, rx[7:0]};
            2'd1:    rdata_asm = {16'h0, rx[7:0], rx[15:8]};
            default: rdata_asm = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (accept) state_d = CMD;
            CMD:     if (phase_end) state_d = ADDR;
            ADDR:    if (phase_end) state_d = DATA;
            DATA:    if (phase_end) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            spi_cs_n   <= 1'b1;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx         <= '0;
            rx         <= '0;
            write_q    <= 1'b0;
            size_q     <= '0;
        end else begin
            state      <= state_d;
            req_ready  <= (state_d == IDLE);
            resp_valid <= 1'b0;
            if (accept) begin
                spi_cs_n <= 1'b0;
                spi_sclk <= 1'b0;
                spi_mosi <= cmd[7];
                div_cnt  <= '0;
                bit_cnt  <= 5'd7;
                write_q  <= req_write;
                size_q   <= req_size;
                rx       <= '0;
                tx       <= {cmd, req_addr, req_write ? wdata_stream : 32'h0};
            end else if (active) begin
                div_cnt <= tick ? '0 : div_cnt + 8'd1;
                if (sclk_rise) begin
                    spi_sclk <= 1'b1;
                    if (state == DATA && !write_q)
                        rx <= {rx[30:0], spi_miso};
                end
                if (sclk_fall) begin
                    spi_sclk <= 1'b0;
                    if (state == DATA && bit_cnt == '0) begin
                        spi_cs_n   <= 1'b1;
                        spi_mosi   <= 1'b0;
                        resp_valid <= 1'b1;
                        if (!write_q)
                            resp_rdata <= rdata_asm;
                    end else begin
                        // mosi always mirrors tx[63]; read data bits are zero
                        tx       <= {tx[62:0], 1'b0};
                        spi_mosi <= tx[62];
                        if (bit_cnt != '0)
                            bit_cnt <= bit_cnt - 5'd1;
                        else
                            bit_cnt <= (state == CMD) ? 5'd23 : data_last;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Bench for spi_mem_ctrl: two instances (HALF_PERIOD 1 and 2) against an
// SPI slave model and a byte-level transaction reference.
module tb_spi_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, sel;
    logic        req_write;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic [31:0] req_wdata;
    logic        miso;

    logic        rdy1, rv1, cs1, sck1, mo1;
    logic [31:0] rd1;
    logic        rdy2, rv2, cs2, sck2, mo2;
    logic [31:0] rd2;
    logic        v1, v2;

    logic        m_ready, m_rv, m_cs_n, m_sclk, m_mosi;
    logic [31:0] m_rdata;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    logic [31:0] slave_word;
    int unsigned bitpos;
    bit          mosi_q[$];
    logic [31:0] model_rd [2];

    always #5 clk = ~clk;

    assign v1 = req_valid & ~sel;
    assign v2 = req_valid & sel;
    assign m_ready = sel ? rdy2 : rdy1;
    assign m_rv    = sel ? rv2  : rv1;
    assign m_cs_n  = sel ? cs2  : cs1;
    assign m_sclk  = sel ? sck2 : sck1;
    assign m_mosi  = sel ? mo2  : mo1;
    assign m_rdata = sel ? rd2  : rd1;

    spi_mem_ctrl #(.HALF_PERIOD(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .resp_valid(rv1), .resp_rdata(rd1),
        .spi_cs_n(cs1), .spi_sclk(sck1), .spi_mosi(mo1), .spi_miso(miso)
    );

    spi_mem_ctrl #(.HALF_PERIOD(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_ready(rdy2),
        .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
        .req_wdata(req_wdata), .resp_valid(rv2), .resp_rdata(rd2),
        .spi_cs_n(cs2), .spi_sclk(sck2), .spi_mosi(mo2), .spi_miso(miso)
    );

    // SPI slave: shifts out slave_word little-endian, each byte MSB first, after 32 bits
    always @(negedge m_cs_n) begin
        bitpos = 0;
        mosi_q.delete();
        miso = 1'($urandom);
    end

    always @(negedge m_sclk) begin
        if (m_cs_n === 1'b0) begin
            bitpos++;
            if (bitpos >= 32 && bitpos < 64)
                miso = slave_word[8 * ((bitpos - 32) / 8) + 7 - ((bitpos - 32) % 8)];
            else
                miso = 1'($urandom);
        end
    end

    always @(posedge m_sclk) begin
        if (m_cs_n === 1'b0)
            mosi_q.push_back(m_mosi);
    end

    task automatic do_txn(input bit use2, input bit wr, input logic [23:0] addr,
                          input logic [1:0] size, input logic [31:0] wdata, input bit noise);
        int unsigned h, nb, b, lat, cyc, p;
        bit          got;
        logic [31:0] exp_rd;
        logic [63:0] gv, ev;
        logic [7:0]  bl [8];
        h   = use2 ? 2 : 1;
        nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        b   = 32 + 8 * nb;
        lat = 2 * h * b;
        sel = use2;
        cyc = 0;
        while (m_ready !== 1'b1 && cyc < 50) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_checks++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: req_ready=%b expected 1", m_ready);
        end
        req_write = wr; req_addr = addr; req_size = size; req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if ({m_cs_n, m_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL accept: cs_n,ready=%b expected 00", {m_cs_n, m_ready});
        end
        got = 0;
        for (cyc = 1; cyc <= lat + 20; cyc++) begin
            if (noise && cyc + 6 < lat) begin
                req_valid = 1'($urandom);
                req_addr  = 24'($urandom);
                req_write = 1'($urandom);
                req_size  = 2'($urandom);
                req_wdata = $urandom;
            end else begin
                req_valid = 1'b0;
            end
            @(posedge clk); #1;
            if (m_rv === 1'b1) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got || cyc != lat) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles (seen=%0d) expected %0d", cyc, got, lat);
        end
        exp_rd = model_rd[use2];
        if (!wr) begin
            exp_rd = '0;
            for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = slave_word[8*i +: 8];
        end
        n_checks++;
        if (m_rdata !== exp_rd) begin
            n_fail++;
            $display("FAIL rdata: got %h expected %h", m_rdata, exp_rd);
        end
        model_rd[use2] = exp_rd;
        n_checks++;
        if (mosi_q.size() != b) begin
            n_fail++;
            $display("FAIL sclk_pulses: got %0d expected %0d", mosi_q.size(), b);
        end
        bl[0] = wr ? 8'h02 : 8'h03;
        bl[1] = addr[23:16]; bl[2] = addr[15:8]; bl[3] = addr[7:0];
        for (int i = 0; i < 4; i++) bl[4+i] = (wr && i < nb) ? wdata[8*i +: 8] : 8'h00;
        gv = '0; ev = '0;
        for (int i = 0; i < 64; i++) begin
            p = i;
            if (i < mosi_q.size()) gv[63-i] = mosi_q[i];
            if (i < b) ev[63-i] = bl[p/8][7-(p%8)];
        end
        n_checks++;
        if (gv !== ev) begin
            n_fail++;
            $display("FAIL mosi_stream: got %h expected %h", gv, ev);
        end
        n_checks++;
        if (m_cs_n !== 1'b1) begin
            n_fail++;
            $display("FAIL cs_at_done: cs_n=%b expected 1", m_cs_n);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({m_ready, m_rv} !== 2'b10) begin
            n_fail++;
            $display("FAIL after_done: ready,resp_valid=%b expected 10", {m_ready, m_rv});
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req_valid = 1'b0; sel = 1'b0;
        req_write = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0;
        slave_word = '0; miso = 1'b0;
        #12;
        n_checks++;
        if ({cs1, sck1, mo1, rv1, rdy1, cs2, sck2, mo2, rv2, rdy2} !== 10'b1000010000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 1000010000",
                     {cs1, sck1, mo1, rv1, rdy1, cs2, sck2, mo2, rv2, rdy2});
        end
        n_checks++;
        if ({rd1, rd2} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h expected 0", {rd1, rd2});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b expected 0", rdy1);
        end
        @(posedge clk); #1;
        n_checks++;
        if ({rdy1, rdy2} !== 2'b11) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b expected 11", {rdy1, rdy2});
        end
        model_rd[0] = '0;
        model_rd[1] = '0;
    endtask

    task automatic test_read4_h1;
        slave_word = 32'h00000513;
        do_txn(0, 0, 24'h000104, 2'd2, 32'h0, 0);
    endtask

    task automatic test_write1_h1;
        slave_word = $urandom;
        do_txn(0, 1, 24'h0000FF, 2'd0, 32'hDEADBEA5, 0);
    endtask

    task automatic test_read2_h2;
        slave_word = {16'($urandom), 16'hCDAB};
        do_txn(1, 0, 24'($urandom), 2'd1, 32'h0, 0);
    endtask

    task automatic test_busy_noise;
        slave_word = $urandom;
        do_txn(0, 0, 24'h5A5A5A, 2'd2, 32'h0, 1);
    endtask

    task automatic test_back_to_back;
        logic [31:0] sw1, sw2;
        int unsigned cyc;
        bit got;
        sel = 1'b0;
        sw1 = $urandom; sw2 = $urandom;
        slave_word = sw1;
        req_write = 1'b0; req_addr = 24'($urandom); req_size = 2'd0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (cs1 !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_first_accept: cs_n=%b expected 0", cs1);
        end
        got = 0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            if (rv1 === 1'b1) begin got = 1; break; end
        end
        n_checks++;
        if (!got || cyc != 80 || rd1 !== {24'h0, sw1[7:0]}) begin
            n_fail++;
            $display("FAIL b2b_first_resp: cycles %0d rdata %h expected 80 %h", cyc, rd1, {24'h0, sw1[7:0]});
        end
        slave_word = sw2;
        @(posedge clk); #1;
        n_checks++;
        if ({rdy1, cs1} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_gap: ready,cs_n=%b expected 11", {rdy1, cs1});
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        n_checks++;
        if ({rdy1, cs1} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_second_accept: ready,cs_n=%b expected 00", {rdy1, cs1});
        end
        got = 0;
        for (cyc = 1; cyc <= 100; cyc++) begin
            @(posedge clk); #1;
            if (rv1 === 1'b1) begin got = 1; break; end
        end
        n_checks++;
        if (!got || cyc != 80 || rd1 !== {24'h0, sw2[7:0]}) begin
            n_fail++;
            $display("FAIL b2b_second_resp: cycles %0d rdata %h expected 80 %h", cyc, rd1, {24'h0, sw2[7:0]});
        end
        model_rd[0] = {24'h0, sw2[7:0]};
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int unsigned seen;
        sel = 1'b0;
        slave_word = $urandom;
        req_write = 1'b0; req_addr = 24'h123456; req_size = 2'd2;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        // bit 18 (ADDR bit 10) rises at E0+37
        repeat (37) @(posedge clk);
        #1;
        n_checks++;
        if ({cs1, sck1} !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset: cs_n,sclk=%b expected 01", {cs1, sck1});
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({cs1, sck1, mo1, rv1, rdy1} !== 5'b10000 || rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL async_reset: cs,sclk,mosi,rv,ready=%b rdata=%h expected 10000 0",
                     {cs1, sck1, mo1, rv1, rdy1}, rd1);
        end
        model_rd[0] = '0;
        model_rd[1] = '0;
        seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (rv1 === 1'b1) seen++;
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (rdy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_before_edge: got %b expected 0", rdy1);
        end
        @(posedge clk); #1;
        if (rv1 === 1'b1) seen++;
        n_checks++;
        if (rdy1 !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_ready_after_release: got %b expected 1", rdy1);
        end
        repeat (100) begin
            @(posedge clk); #1;
            if (rv1 === 1'b1) seen++;
        end
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL no_resp_after_reset: got %0d pulses expected 0", seen);
        end
        slave_word = $urandom;
        do_txn(0, 0, 24'($urandom), 2'd2, 32'h0, 0);
    endtask

    task automatic test_random;
        logic [23:0] a;
        logic [1:0]  s;
        for (int i = 0; i < 14; i++) begin
            a = (i == 0) ? 24'hFFFFFF : 24'($urandom);
            s = (i == 1) ? 2'd3 : 2'($urandom);
            slave_word = $urandom;
            do_txn(1'($urandom), 1'($urandom), a, s, $urandom, (i % 4) == 3);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read4_h1();
        test_write1_h1();
        test_read2_h2();
        test_back_to_back();
        test_busy_noise();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_mem_ctrl.md
# spi_mem_ctrl

SPI memory controller for the RV32E mini-MCU: converts single-word load/store/fetch requests from the core into SPI mode-0 READ (0x03) and WRITE (0x02) transactions to an external SPI flash or SRAM on the Tiny Tapeout IO pins. It sits directly upstream of the core's fetch and load/store path and drives the SPI pins that the top level maps onto `uio_out`/`uio_oe`/`uio_in`.

## Interface

Parameters:
- `HALF_PERIOD`, default 1: number of `clk` cycles per SCLK half-period; legal values are 1..255.

Ports:
- `clk`  input  1  system clock; all logic is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `req_valid`  input  1  the core presents a request.
- `req_ready`  output  1  the controller is idle and can accept a request.
- `req_write`  input  1  1 selects WRITE (0x02); 0 selects READ (0x03).
- `req_addr`  input  24  byte address.
- `req_size`  input  2  transfer size: 0 = 1 byte, 1 = 2 bytes, 2 or 3 = 4 bytes.
- `req_wdata`  input  32  write data; `[7:0]` is sent first.
- `resp_valid`  output  1  one-cycle pulse marking the end of a transaction.
- `resp_rdata`  output  32  read data; held until the next read response.
- `spi_cs_n`  output  1  chip select, active low.
- `spi_sclk`  output  1  serial clock; idles low.
- `spi_mosi`  output  1  serial data out.
- `spi_miso`  input  1  serial data in.

## Operation

- **Handshake.** A request is accepted on a rising edge where `req_valid && req_ready` is true. All `req_*` fields are latched at that edge and are ignored afterwards. `req_ready` is high only in IDLE.
- **State machine.**
  - IDLE -> CMD on accept.
  - CMD (8 bits) -> ADDR (24 bits) -> DATA (N bits) -> DONE -> IDLE.
  - N = 8, 16 or 32 bits, set by `req_size`.
  - DONE lasts exactly one cycle.
- **Bit order.** Command and address are shifted MSB first. Data is sent byte-serial in little-endian byte order: byte 0 goes to/from bits `[7:0]`, and each byte is MSB first.
- **SPI mode 0.**
  - MOSI changes only on SCLK falling edges, or at the accept edge for the first bit.
  - MISO is sampled on every SCLK rising edge during DATA of a READ.
  - MOSI is driven 0 during read DATA and while idle.
- **Read data.**
  - Bytes not covered by `req_size` are returned as 0 (zero-extended).
  - `resp_rdata` updates only at DONE of a READ.
  - A WRITE leaves `resp_rdata` unchanged.
- **Reset (asynchronous, also mid-transfer).** Outputs take these values immediately:
  - `spi_cs_n`=1, `spi_sclk`=0, `spi_mosi`=0
  - `resp_valid`=0, `resp_rdata`=0, `req_ready`=0
  - The state returns to IDLE and the in-flight transaction is discarded with no response.
  - `req_ready` rises on the first `clk` edge after `rst_n` deasserts.
- **Boundary cases.**
  - `req_valid` while busy is ignored and does not stall or corrupt the transfer.
  - An address at 0xFFFFFF is sent as-is; wrap-around is the device's behaviour.
  - `req_size`=3 behaves exactly as `req_size`=2.

## Timing

Let E0 be the accept edge, H = `HALF_PERIOD` and B = 32 + N (total bits).

- **E0:** `spi_cs_n` falls, MOSI carries command bit 7, and `req_ready` falls.
- **Bit k** (k = 0..B-1): SCLK rises at E0 + (2k+1)·H and falls at E0 + (2k+2)·H.
- **Last falling edge**, at E0 + 2·H·B:
  - `spi_cs_n` rises and the state enters DONE.
  - `resp_valid`=1 for exactly one cycle.
  - `resp_rdata` is valid in that same cycle.
- **Following edge:** IDLE; `req_ready`=1.
- **Latency, accept to `resp_valid`:** 2·H·B cycles. Examples: a 4-byte read at H=1 takes 128 cycles; a 1-byte read at H=1 takes 80 cycles.
- **Chip-select gap.** Minimum `spi_cs_n` high time between back-to-back transactions is 2 `clk` cycles (DONE + IDLE accept cycle).
- **Clock shape.** SCLK has a 50% duty cycle at frequency clk/(2·H). There are no partial SCLK pulses at start or end.

## Test plan

- **4-byte read at H=1.** Request READ, addr 0x000104, size 2; the SPI model returns bytes 0x13, 0x05, 0x00, 0x00.
  - MOSI carries 0x03 then 0x000104.
  - `resp_valid` is high 128 cycles after accept.
  - `resp_rdata` = 0x00000513.
- **1-byte write at H=1.** Request WRITE, addr 0x0000FF, size 0, wdata 0xDEADBEA5.
  - MOSI carries 0x02, 0x0000FF, 0xA5; 40 SCLK pulses.
  - `resp_valid` fires at cycle 80.
  - `resp_rdata` keeps its previous value.
- **2-byte read at H=2.** Request size 1; the model returns 0xAB, 0xCD.
  - SCLK period is 4 cycles.
  - `resp_rdata` = 0x0000CDAB at cycle 192.
- **Back-to-back requests.** Hold `req_valid` high for two reads.
  - The second accept occurs 2 cycles after the first `resp_valid`.
  - `spi_cs_n` is high for exactly 2 cycles between transactions.
- **Request while busy.** Toggle `req_valid` and change `req_addr` during a transfer.
  - The shifted-out address stays equal to the latched one.
  - Exactly one `resp_valid` is produced.
- **Reset mid-transfer.** Pulse `rst_n` low during ADDR bit 10.
  - `spi_cs_n` rises and `spi_sclk` drops in the same cycle, without waiting for a clock edge.
  - No `resp_valid` is produced.
  - `req_ready` rises 1 cycle after release.
  - A new read then completes correctly.
